tlc_nphase: RTL and testbench

TLC_NPHASE -- requirements
Module: tlc_nphase

---
 rtl/light_package.sv | 33 +++
 rtl/tlc_nphase_if.sv | 27 ++
 rtl/tlc_rr_arbiter.sv | 29 ++
 rtl/tlc_nphase.sv | 159 +++++++++++++++
 tb/tb_tlc_nphase.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/light_package.sv
// Shared light colours, controller phase states and the default five-phase
// light map for the N-phase traffic light controller.
package light_package;

  typedef enum logic [1:0] {
    COL_RED = 2'd0,
    COL_YEL = 2'd1,
    COL_GRN = 2'd2
  } colors;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } tlc_phase_state_e;

  // Light head bit positions used by the default map
  localparam int unsigned L_ES = 0;
  localparam int unsigned L_EL = 1;
  localparam int unsigned L_WS = 2;
  localparam int unsigned L_WL = 3;
  localparam int unsigned L_NS = 4;

  // Phase 0..4 = {ES+WS, EL+ES, WL+WS, WL+EL, NS}; entry 4 is leftmost
  localparam logic [4:0][4:0] DEFAULT_MAP = {
    5'b10000,
    5'b01010,
    5'b01100,
    5'b00011,
    5'b00101
  };

endpackage

// File: rtl/tlc_nphase_if.sv
// Sensor/preempt inputs and light/phase outputs of the N-phase controller.
interface tlc_nphase_if
  import light_package::*;
#(
  parameter int NLIGHT = 5,
  parameter int NPHASE = 5
);
  localparam int PW = $clog2(NPHASE);

  logic [NLIGHT-1:0]        sensor;
  logic                     preempt;
  logic [PW-1:0]            preempt_phase;
  colors [NLIGHT-1:0]       light;
  logic [PW-1:0]            phase_idx;
  tlc_phase_state_e         phase_state;

  modport master (
    output sensor, preempt, preempt_phase,
    input  light, phase_idx, phase_state
  );

  modport slave (
    input  sensor, preempt, preempt_phase,
    output light, phase_idx, phase_state
  );

endinterface

// File: rtl/tlc_rr_arbiter.sv
// Round-robin phase picker: first requesting phase after i_last, with wrap;
// the phase at i_last itself is considered last.
module tlc_rr_arbiter #(
  parameter int NPHASE = 5,
  localparam int PW = $clog2(NPHASE)
) (
  input  logic [NPHASE-1:0] i_req,
  input  logic [PW-1:0]     i_last,
  output logic [PW-1:0]     o_grant,
  output logic              o_valid
);

  int w_k;

  // Walk from farthest to nearest so the nearest requester wins
  always_comb begin
    o_grant = i_last;
    o_valid = 1'b0;
    w_k     = 0;
    for (int i = NPHASE; i >= 1; i--) begin
      w_k = (int'(i_last) + i) % NPHASE;
      if (i_req[w_k]) begin
        o_grant = PW'(w_k);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlc_nphase.sv
// N-phase traffic light controller with gap-out / max-green timing.
// Optional emergency preemption is built when TLC_PREEMPT_EN is defined.
module tlc_nphase
  import light_package::*;
#(
  parameter int NLIGHT   = 5,
  parameter int NPHASE   = 5,
  parameter logic [NPHASE-1:0][NLIGHT-1:0] PHASE_MAP = DEFAULT_MAP,
  parameter int YEL_CYC  = 2,
  parameter int RED_CYC  = 1,
  parameter int HOLD_CYC = 5,
  parameter int MAXG_CYC = 10
) (
  input  logic          clk,
  input  logic          reset,
  tlc_nphase_if.slave   bus
);

  localparam int PW = $clog2(NPHASE);
  localparam int CW = $clog2(MAXG_CYC + HOLD_CYC + YEL_CYC + RED_CYC + 1);
  localparam logic [CW-1:0] RED_LIM  = CW'(RED_CYC - 1);
  localparam logic [CW-1:0] YEL_LIM  = CW'(YEL_CYC - 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_CYC);
  localparam logic [CW-1:0] MAXG_LIM = CW'(MAXG_CYC);

  typedef colors [NLIGHT-1:0] light_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v,
                                            input logic [CW-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

  function automatic light_t light_vec(input tlc_phase_state_e st,
                                       input logic [PW-1:0]    ph);
    light_t lv;
    for (int l = 0; l < NLIGHT; l++) begin
      lv[l] = COL_RED;
      if (PHASE_MAP[ph][l] && st == GREEN)       lv[l] = COL_GRN;
      else if (PHASE_MAP[ph][l] && st == YELLOW) lv[l] = COL_YEL;
    end
    return lv;
  endfunction

  tlc_phase_state_e r_state;
  logic [PW-1:0]    r_phase;
  logic [CW-1:0]    r_tmr;
  logic [CW-1:0]    r_gap;
  logic [CW-1:0]    r_max;
  light_t           r_light;

  logic [NPHASE-1:0] w_req;
  logic              w_own;
  logic              w_conf;
  logic [CW-1:0]     w_gap_n;
  logic [CW-1:0]     w_max_n;
  logic [PW-1:0]     w_arb_idx;
  logic              w_arb_vld;
  logic              w_go;
  logic [PW-1:0]     w_nxt;
  logic              w_pre_yel;
  logic              w_pre_hold;

  always_comb begin
    w_req = '0;
    for (int p = 0; p < NPHASE; p++) w_req[p] = |(bus.sensor & PHASE_MAP[p]);
  end

  assign w_own   = |(bus.sensor & PHASE_MAP[r_phase]);
  assign w_conf  = |(bus.sensor & ~PHASE_MAP[r_phase]);
  assign w_gap_n = w_own ? '0 : sat_inc(r_gap, HOLD_LIM);
  assign w_max_n = sat_inc(r_max, MAXG_LIM);

  tlc_rr_arbiter #(.NPHASE(NPHASE)) u_arb (
    .i_req   (w_req),
    .i_last  (r_phase),
    .o_grant (w_arb_idx),
    .o_valid (w_arb_vld)
  );

`ifdef TLC_PREEMPT_EN
  logic w_pre;
  assign w_pre      = bus.preempt && (int'(bus.preempt_phase) < NPHASE);
  assign w_go       = w_pre || w_arb_vld;
  assign w_nxt      = w_pre ? bus.preempt_phase : w_arb_idx;
  assign w_pre_yel  = w_pre && (bus.preempt_phase != r_phase);
  assign w_pre_hold = w_pre && (bus.preempt_phase == r_phase);
`else
  // Preempt ports exist but are not connected to any logic in this build
  logic w_unused_pre;
  assign w_unused_pre = ^{bus.preempt, bus.preempt_phase};
  assign w_go       = w_arb_vld;
  assign w_nxt      = w_arb_idx;
  assign w_pre_yel  = 1'b0;
  assign w_pre_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ALLRED;
      r_phase <= PW'(NPHASE - 1);
      r_tmr   <= '0;
      r_gap   <= '0;
      r_max   <= '0;
      r_light <= light_vec(ALLRED, '0);
    end else begin
      unique case (r_state)
        ALLRED: begin
          if (r_tmr != RED_LIM) begin
            r_tmr <= r_tmr + 1'b1;
          end else if (w_go) begin
            r_state <= GREEN;
            r_phase <= w_nxt;
            r_tmr   <= '0;
            r_light <= light_vec(GREEN, w_nxt);
          end
        end
        GREEN: begin
          // Counters are evaluated on their post-increment value so the
          // change happens on the edge where a limit is reached
          if (w_pre_yel || (!w_pre_hold && w_conf &&
                            (w_gap_n == HOLD_LIM || w_max_n == MAXG_LIM))) begin
            r_state <= YELLOW;
            r_tmr   <= '0;
            r_gap   <= '0;
            r_max   <= '0;
            r_light <= light_vec(YELLOW, r_phase);
          end else if (w_pre_hold || !w_conf) begin
            r_gap <= '0;
            r_max <= '0;
          end else begin
            r_gap <= w_gap_n;
            r_max <= w_max_n;
          end
        end
        YELLOW: begin
          if (r_tmr == YEL_LIM) begin
            r_state <= ALLRED;
            r_tmr   <= '0;
            r_light <= light_vec(ALLRED, r_phase);
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        default: begin
          r_state <= ALLRED;
          r_tmr   <= '0;
          r_gap   <= '0;
          r_max   <= '0;
          r_light <= light_vec(ALLRED, r_phase);
        end
      endcase
    end
  end

  assign bus.light       = r_light;
  assign bus.phase_idx   = r_phase;
  assign bus.phase_state = r_state;

endmodule

// File: tb/tb_tlc_nphase.sv
// Directed bench for tlc_nphase using the default five-phase map;
// covers the preempt behaviour of whichever build TLC_PREEMPT_EN selects.
module tb_tlc_nphase;
  import light_package::*;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   m_chk  = 0;
  int   m_fail = 0;

  // Independent copy of the default map, phase 0 rightmost
  localparam logic [4:0][4:0] MAP = {5'b10000, 5'b01010, 5'b01100, 5'b00011, 5'b00101};

  tlc_nphase_if #(.NLIGHT(5), .NPHASE(5)) bus ();

  tlc_nphase dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Property monitor: lights match state/phase, and state moves only along legal arcs
  tlc_phase_state_e m_prev;
  logic [2:0]       m_prev_idx;
  logic [9:0]       m_exp;
  logic [9:0]       m_lv;
  bit               m_prev_ok = 1'b0;
  bit               m_bad;
  initial forever begin
    @(negedge clk);
    if (reset) begin
      m_prev_ok = 1'b0;
    end else begin
      m_exp = '0;
      for (int l = 0; l < 5; l++) begin
        if (MAP[bus.phase_idx][l] && bus.phase_state == GREEN)  m_exp[2*l +: 2] = COL_GRN;
        if (MAP[bus.phase_idx][l] && bus.phase_state == YELLOW) m_exp[2*l +: 2] = COL_YEL;
      end
      m_lv = bus.light;
      m_chk++;
      if (m_lv !== m_exp) begin
        m_fail++;
        $display("FAIL mon_lights: light=%h required=%h (state=%0d idx=%0d)", m_lv, m_exp, bus.phase_state, bus.phase_idx);
      end
      if (m_prev_ok) begin
        m_bad = (m_prev == GREEN  && bus.phase_state == ALLRED) ||
                (m_prev == YELLOW && bus.phase_state == GREEN)  ||
                (m_prev == ALLRED && bus.phase_state == YELLOW) ||
                (bus.phase_idx != m_prev_idx && !(m_prev == ALLRED && bus.phase_state == GREEN));
        m_chk++;
        if (m_bad) begin
          m_fail++;
          $display("FAIL mon_transition: %0d/%0d -> %0d/%0d is not a legal step",
                   m_prev, m_prev_idx, bus.phase_state, bus.phase_idx);
        end
      end
      m_prev     = bus.phase_state;
      m_prev_idx = bus.phase_idx;
      m_prev_ok  = 1'b1;
    end
  end

  task automatic test_reset();
    logic [9:0] lv;
    reset = 1'b1;
    bus.sensor = '0;
    bus.preempt = 1'b0;
    bus.preempt_phase = '0;
    tick(2);
    lv = bus.light;
    n_chk++;
    if (bus.phase_state !== ALLRED) begin n_fail++; $display("FAIL reset_state: got %0d need ALLRED", bus.phase_state); end
    n_chk++;
    if (bus.phase_idx !== 3'd4) begin n_fail++; $display("FAIL reset_idx: got %0d need 4", bus.phase_idx); end
    n_chk++;
    if (lv !== 10'h000) begin n_fail++; $display("FAIL reset_lights: got %h need 000", lv); end
  endtask

  task automatic test_single_demand();
    logic [9:0] lv;
    int bad;
    bus.sensor = 5'b00001;
    reset = 1'b0;
    n_chk++;
    if (bus.phase_state !== ALLRED) begin n_fail++; $display("FAIL single_allred: got %0d need ALLRED", bus.phase_state); end
    tick(1);
    lv = bus.light;
    n_chk++;
    if (bus.phase_state !== GREEN || bus.phase_idx !== 3'd0) begin
      n_fail++; $display("FAIL single_green: state %0d idx %0d need GREEN/0", bus.phase_state, bus.phase_idx);
    end
    n_chk++;
    if (lv !== 10'h022) begin n_fail++; $display("FAIL single_lights: got %h need 022", lv); end
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      tick(1);
      if (bus.phase_state !== GREEN || bus.phase_idx !== 3'd0) bad++;
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL single_hold50: %0d cycles left green, need 0", bad); end
  endtask

  task automatic test_max_green();
    logic [9:0] lv;
    int bad;
    bus.sensor = 5'b10001;
    bad = 0;
    for (int c = 1; c <= 9; c++) begin
      tick(1);
      if (bus.phase_state !== GREEN) bad++;
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL maxg_early: %0d of 9 cycles not green, need 0", bad); end
    tick(1);
    lv = bus.light;
    n_chk++;
    if (bus.phase_state !== YELLOW || lv !== 10'h011) begin
      n_fail++; $display("FAIL maxg_yellow: state %0d lights %h need YELLOW/011", bus.phase_state, lv);
    end
    tick(1);
    n_chk++;
    if (bus.phase_state !== YELLOW) begin n_fail++; $display("FAIL maxg_yel2: state %0d need YELLOW", bus.phase_state); end
    bus.sensor = 5'b10000;
    tick(1);
    lv = bus.light;
    n_chk++;
    if (bus.phase_state !== ALLRED || lv !== 10'h000) begin
      n_fail++; $display("FAIL maxg_allred: state %0d lights %h need ALLRED/000", bus.phase_state, lv);
    end
    tick(1);
    lv = bus.light;
    n_chk++;
    if (bus.phase_state !== GREEN || bus.phase_idx !== 3'd4 || lv !== 10'h200) begin
      n_fail++; $display("FAIL maxg_ns_green: state %0d idx %0d lights %h need GREEN/4/200", bus.phase_state, bus.phase_idx, lv);
    end
  endtask

  task automatic test_gap_out();
    int bad;
    reset = 1'b1;
    bus.sensor = 5'b00001;
    tick(1);
    reset = 1'b0;
    tick(1);
    n_chk++;
    if (bus.phase_state !== GREEN || bus.phase_idx !== 3'd0) begin
      n_fail++; $display("FAIL gap_start: state %0d idx %0d need GREEN/0", bus.phase_state, bus.phase_idx);
    end
    bus.sensor = 5'b10001;
    tick(2);
    bus.sensor = 5'b10000;
    bad = 0;
    for (int c = 1; c <= 4; c++) begin
      tick(1);
      if (bus.phase_state !== GREEN) bad++;
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL gap_early: %0d of 4 cycles not green, need 0", bad); end
    tick(1);
    n_chk++;
    if (bus.phase_state !== YELLOW || bus.phase_idx !== 3'd0) begin
      n_fail++; $display("FAIL gap_yellow: state %0d idx %0d need YELLOW/0", bus.phase_state, bus.phase_idx);
    end
    tick(2);
    n_chk++;
    if (bus.phase_state !== ALLRED) begin n_fail++; $display("FAIL gap_allred: state %0d need ALLRED", bus.phase_state); end
    tick(1);
    n_chk++;
    if (bus.phase_state !== GREEN || bus.phase_idx !== 3'd4) begin
      n_fail++; $display("FAIL gap_ns_green: state %0d idx %0d need GREEN/4", bus.phase_state, bus.phase_idx);
    end
  endtask

  task automatic test_idle_and_self_grant();
    logic [9:0] lv;
    int bad;
    bus.sensor = 5'b00001;
    tick(4);
    n_chk++;
    if (bus.phase_state !== GREEN) begin n_fail++; $display("FAIL idle_green: state %0d need GREEN", bus.phase_state); end
    tick(1);
    lv = bus.light;
    n_chk++;
    if (bus.phase_state !== YELLOW || lv !== 10'h100) begin
      n_fail++; $display("FAIL idle_yellow: state %0d lights %h need YELLOW/100", bus.phase_state, lv);
    end
    bus.sensor = 5'b00000;
    tick(2);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.phase_state !== ALLRED || bus.phase_idx !== 3'd4) bad++;
      tick(1);
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL idle_hold: %0d of 5 cycles not ALLRED/4, need 0", bad); end
    bus.sensor = 5'b10000;
    tick(1);
    n_chk++;
    if (bus.phase_state !== GREEN || bus.phase_idx !== 3'd4) begin
      n_fail++; $display("FAIL self_grant: state %0d idx %0d need GREEN/4", bus.phase_state, bus.phase_idx);
    end
  endtask

  task automatic test_round_robin();
    int seq[6];
    int at[6];
    int ng;
    tlc_phase_state_e prev;
    reset = 1'b1;
    bus.sensor = 5'b11111;
    tick(1);
    reset = 1'b0;
    ng = 0;
    prev = ALLRED;
    for (int t = 1; t <= 100 && ng < 6; t++) begin
      tick(1);
      if (bus.phase_state == GREEN && prev != GREEN) begin
        seq[ng] = int'(bus.phase_idx);
        at[ng]  = t;
        ng++;
      end
      prev = bus.phase_state;
    end
    n_chk++;
    if (ng != 6) begin n_fail++; $display("FAIL rr_count: %0d greens within 100 cycles, need 6", ng); end
    for (int i = 0; i < ng; i++) begin
      n_chk++;
      if (seq[i] != i % 5) begin n_fail++; $display("FAIL rr_order[%0d]: phase %0d need %0d", i, seq[i], i % 5); end
    end
    for (int i = 1; i < ng; i++) begin
      n_chk++;
      if (at[i] - at[i-1] != 13) begin n_fail++; $display("FAIL rr_period[%0d]: %0d cycles need 13", i, at[i] - at[i-1]); end
    end
  endtask

  task automatic test_reset_mid_phase();
    logic [9:0] lv;
    int bad;
    reset = 1'b1;
    bus.sensor = 5'b10001;
    tick(1);
    reset = 1'b0;
    tick(6);
    reset = 1'b1;
    tick(1);
    lv = bus.light;
    n_chk++;
    if (bus.phase_state !== ALLRED || bus.phase_idx !== 3'd4 || lv !== 10'h000) begin
      n_fail++; $display("FAIL rst_green: state %0d idx %0d lights %h need ALLRED/4/000", bus.phase_state, bus.phase_idx, lv);
    end
    reset = 1'b0;
    tick(1);
    bad = 0;
    for (int c = 1; c <= 9; c++) begin
      tick(1);
      if (bus.phase_state !== GREEN || bus.phase_idx !== 3'd0) bad++;
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL rst_green_maxclr: %0d of 9 cycles not green, need 0", bad); end
    tick(1);
    n_chk++;
    if (bus.phase_state !== YELLOW) begin n_fail++; $display("FAIL rst_to_yellow: state %0d need YELLOW", bus.phase_state); end
    reset = 1'b1;
    tick(1);
    lv = bus.light;
    n_chk++;
    if (bus.phase_state !== ALLRED || bus.phase_idx !== 3'd4 || lv !== 10'h000) begin
      n_fail++; $display("FAIL rst_yellow: state %0d idx %0d lights %h need ALLRED/4/000", bus.phase_state, bus.phase_idx, lv);
    end
    reset = 1'b0;
    tick(1);
    n_chk++;
    if (bus.phase_state !== GREEN || bus.phase_idx !== 3'd0) begin
      n_fail++; $display("FAIL rst_first_green: state %0d idx %0d need GREEN/0", bus.phase_state, bus.phase_idx);
    end
    tick(9);
    n_chk++;
    if (bus.phase_state !== GREEN) begin n_fail++; $display("FAIL rst_yel_cntclr: state %0d need GREEN", bus.phase_state); end
    tick(1);
    n_chk++;
    if (bus.phase_state !== YELLOW) begin n_fail++; $display("FAIL rst_yel_maxout: state %0d need YELLOW", bus.phase_state); end
  endtask

  task automatic test_preempt();
    logic [9:0] lv;
    int bad;
    reset = 1'b1;
    bus.sensor = 5'b00010;
    tick(1);
    reset = 1'b0;
    tick(1);
    lv = bus.light;
    n_chk++;
    if (bus.phase_state !== GREEN || bus.phase_idx !== 3'd1 || lv !== 10'h00A) begin
      n_fail++; $display("FAIL pre_start: state %0d idx %0d lights %h need GREEN/1/00A", bus.phase_state, bus.phase_idx, lv);
    end
    bus.preempt = 1'b1;
    bus.preempt_phase = 3'd4;
`ifdef TLC_PREEMPT_EN
    tick(1);
    lv = bus.light;
    n_chk++;
    if (bus.phase_state !== YELLOW || lv !== 10'h005) begin
      n_fail++; $display("FAIL pre_yellow: state %0d lights %h need YELLOW/005", bus.phase_state, lv);
    end
    tick(3);
    n_chk++;
    if (bus.phase_state !== GREEN || bus.phase_idx !== 3'd4) begin
      n_fail++; $display("FAIL pre_grant: state %0d idx %0d need GREEN/4", bus.phase_state, bus.phase_idx);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (bus.phase_state !== GREEN || bus.phase_idx !== 3'd4) bad++;
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL pre_hold: %0d of 20 cycles not GREEN/4, need 0", bad); end
    bus.preempt = 1'b0;
    tick(4);
    n_chk++;
    if (bus.phase_state !== GREEN) begin n_fail++; $display("FAIL pre_release_green: state %0d need GREEN", bus.phase_state); end
    tick(1);
    n_chk++;
    if (bus.phase_state !== YELLOW || bus.phase_idx !== 3'd4) begin
      n_fail++; $display("FAIL pre_release_gap: state %0d idx %0d need YELLOW/4", bus.phase_state, bus.phase_idx);
    end
`else
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (bus.phase_state !== GREEN || bus.phase_idx !== 3'd1) bad++;
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL pre_ignored: %0d of 20 cycles not GREEN/1, need 0", bad); end
    bus.preempt = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_single_demand();
    test_max_green();
    test_gap_out();
    test_idle_and_self_grant();
    test_round_robin();
    test_reset_mid_phase();
    test_preempt();
    tick(2);
    n_chk  = n_chk + m_chk;
    n_fail = n_fail + m_fail;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
